eeg_decimator: RTL

EEG_DECIMATOR -- requirements
Module: eeg_decimator

---
 rtl/eeg_decimator.sv | 136 +++++++++++++
 1 files changed

// File: rtl/eeg_decimator.sv
// EEG decimator: keeps one of every DECIM filtered samples, rounds,
// scales and saturates it to 16 bits, and buffers it in a small FIFO.
module eeg_decimator #(
    parameter int DECIM = 4,
    parameter int SHIFT = 15,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [31:0]       in_sample,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [15:0]       out_data,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     ovf,
    output logic                     sat,
    input  logic                     clr_flags
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [4:0] LAST = 5'(DECIM - 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic signed [32:0] RND = 33'sd1 <<< (SHIFT - 1);
    localparam logic signed [32:0] MAXV = 33'sd32767;
    localparam logic signed [32:0] MINV = -33'sd32768;

    logic [4:0]          phase;
    logic                keep;
    logic signed [32:0]  sum;
    logic signed [32:0]  scaled;
    logic signed [15:0]  sat_val;
    logic                clip;
    logic                stage_valid;
    logic signed [15:0]  stage_data;
    logic signed [15:0]  mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                full;
    logic                push;
    logic                pop;
    logic                drop;

    assign keep      = in_valid && (phase == 5'd0);
    assign full      = (fill == FULL_CNT);
    assign out_valid = (fill != '0);
    assign pop       = out_valid && out_ready;
    assign push      = stage_valid && (!full || pop);
    assign drop      = stage_valid && full && !pop;
    assign out_data  = out_valid ? mem[rd_ptr] : 16'sd0;

    // Round-half-up, arithmetic shift, then clamp to the 16-bit range.
    always_comb begin
        sum     = $signed({in_sample[31], in_sample}) + RND;
        scaled  = sum >>> SHIFT;
        clip    = 1'b0;
        sat_val = scaled[15:0];
        if (scaled > MAXV) begin
            sat_val = 16'sh7FFF;
            clip    = 1'b1;
        end else if (scaled < MINV) begin
            sat_val = -16'sh8000;
            clip    = 1'b1;
        end
    end

    // Phase counter advances only on valid inputs and wraps at DECIM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 5'd0;
        end else if (in_valid) begin
            phase <= (phase == LAST) ? 5'd0 : phase + 5'd1;
        end
    end

    // One register stage between the scaler and the FIFO write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid <= 1'b0;
            stage_data  <= 16'sd0;
        end else begin
            stage_valid <= keep;
            if (keep) begin
                stage_data <= sat_val;
            end
        end
    end

    // Sticky flags; a new event in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
            sat <= 1'b0;
        end else begin
            if (drop) begin
                ovf <= 1'b1;
            end else if (clr_flags) begin
                ovf <= 1'b0;
            end
            if (keep && clip) begin
                sat <= 1'b1;
            end else if (clr_flags) begin
                sat <= 1'b0;
            end
        end
    end

    // FIFO storage; stale entries are unreachable once pointers reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= stage_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fill <= fill + (AW + 1)'(1);
            end else if (pop && !push) begin
                fill <= fill - (AW + 1)'(1);
            end
        end
    end

endmodule
